alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- Single-entry reservation station that sits in front of one ALU.
- Accepts a dispatched ALU op whose source operands are either values or producer tags.
- Snoops the common data bus (CDB) terms to capture missing operands, then issues the op to its ALU with a one-cycle ready pulse.
- It is the CDB consumer side: the ALU broadcasts `{tag, val}` on `cdb_t`, and this block matches tags and captures values.

Parameters:
- TAG, ALU_1, `rs_tag_t` identity of the ALU this station feeds; its result appears on the CDB under this tag.
- NUM_CDB, 2, number of CDB terms snooped each cycle.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- dispatch_valid_i  in  1  dispatch request, single-cycle
- dispatch_op_i  in  alu_op_t  operation
- dispatch_rs1_tag_i  in  rs_tag_t  producer tag for rs1; NO_VAL = value already present
- dispatch_rs1_val_i  in  word32_t  rs1 value; meaningful only when tag = NO_VAL
- dispatch_rs2_tag_i  in  rs_tag_t  producer tag for rs2; NO_VAL = value present
- dispatch_rs2_val_i  in  word32_t  rs2 value or immediate
- cdb_i  in  cdb_t [NUM_CDB]  CDB terms, one per producer
- flush_i  in  1  synchronous squash
- busy_o  out  1  entry occupied; dispatch not accepted
- oper_o  out  alu_op_t  op to ALU
- rs1_val_o  out  word32_t  operand 1 to ALU
- rs2_val_o  out  word32_t  operand 2 to ALU
- ready_o  out  1  issue pulse to ALU `ready_i`

Behaviour:
- States: IDLE, WAIT, BCAST. Reset (async) → IDLE; op/values/tags cleared (op = ADDI, values 0, tags NO_VAL).
- Reset values: busy_o = 0, ready_o = 0, rs1_val_o = rs2_val_o = 0, oper_o = ADDI.
- busy_o = (state == WAIT). ready_o = (state == WAIT) & both held tags == NO_VAL; combinational from registered state, never from inputs.
- Dispatch is accepted when dispatch_valid_i & !busy_o & !flush_i, i.e. in IDLE or BCAST; on acceptance next state = WAIT.
- Dispatch while busy_o = 1 is ignored; this is the dispatcher's error. State and operands are unchanged.
- Forwarding at dispatch: for each source with tag != NO_VAL, if any cdb_i[k].tag equals that tag in the same cycle, capture cdb_i[k].val and store tag NO_VAL. Otherwise store the tag.
- Snoop in WAIT: for each held tag != NO_VAL, on a match with cdb_i[k].tag, capture the value and set the tag to NO_VAL at the edge.
- CDB terms with tag NO_VAL never match.
- Multiple matching terms: lowest k wins. This is illegal upstream, but behaviour is defined.
- Issue: in WAIT with both tags NO_VAL, ready_o = 1 for exactly one cycle. oper_o and the values are held stable, and next state = BCAST.
- An operand captured from the CDB is issued no earlier than the following cycle.
- BCAST: the ALU is broadcasting the result under TAG. The entry is free: busy_o = 0, ready_o = 0, and a dispatch is accepted.
- Dispatch in BCAST with a source tag == TAG captures the broadcast value via forwarding. Without a dispatch, next state = IDLE.
- Latency: dispatch with both operands ready → ready_o on the cycle after acceptance → ALU result on the CDB the cycle after that.
- Steady-state throughput is one op per 2 cycles.
- flush_i: at the edge, state → IDLE and held tags → NO_VAL. flush_i dominates a simultaneous dispatch and a simultaneous issue; ready_o still reflects the current cycle's registered state.
- oper_o, rs1_val_o and rs2_val_o always reflect the held entry, even when ready_o = 0.

Test Plan:
1. Reset asserted mid-WAIT, async and without a clock edge → busy_o = 0, ready_o = 0 immediately; after release, a dispatch of ADDI 5, 7 is accepted normally.
2. Dispatch ADDR, rs1 = 3, rs2 = 4, both NO_VAL, at cycle 0 → ready_o = 1 only in cycle 1, rs1_val_o = 3, rs2_val_o = 4, busy_o = 1 in cycle 1 and 0 in cycle 2.
3. Dispatch SUBR with rs1 tag ALU_2, rs2 = 1; cdb_i[1] = {ALU_2, 0x10} in cycle 3 → ready_o = 1 in cycle 4 with rs1_val_o = 0x10; no ready_o in cycles 1–3.
4. Dispatch with rs1 tag ALU_2 while cdb_i[0] = {ALU_2, 0xAB} in the same cycle → ready_o next cycle with rs1_val_o = 0xAB.
5. Back-to-back: dispatch ADDI 1, 1 (rs2 = 1), then dispatch in the BCAST cycle with rs1 tag = TAG while cdb_i[0] = {TAG, 2} → the second issue has rs1_val_o = 2; issues are spaced 2 cycles apart.
6. Flush in WAIT with a pending tag, plus simultaneous dispatch → next cycle IDLE, busy_o = 0, no ready_o; a later CDB match with the old tag causes no issue.

Source files
------------

// File: rtl/alu_rs.sv
// Single-entry reservation station in front of one ALU: holds a dispatched op,
// snoops the CDB for missing operands and issues with a one-cycle ready pulse.
package alu_rs_pkg;
    typedef logic [31:0] word32_t;

    typedef enum logic [2:0] {
        NO_VAL = 3'd0,
        ALU_1  = 3'd1,
        ALU_2  = 3'd2,
        MUL_1  = 3'd3,
        LSU_1  = 3'd4
    } rs_tag_t;

    typedef enum logic [3:0] {
        ADDI = 4'd0,
        ADDR = 4'd1,
        SUBR = 4'd2,
        ANDR = 4'd3,
        ORR  = 4'd4,
        XORR = 4'd5,
        SLLR = 4'd6,
        SRLR = 4'd7
    } alu_op_t;

    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;
endpackage

module alu_rs
    import alu_rs_pkg::*;
#(
    parameter rs_tag_t TAG     = ALU_1,
    parameter int      NUM_CDB = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      dispatch_valid_i,
    input  alu_op_t                   dispatch_op_i,
    input  rs_tag_t                   dispatch_rs1_tag_i,
    input  word32_t                   dispatch_rs1_val_i,
    input  rs_tag_t                   dispatch_rs2_tag_i,
    input  word32_t                   dispatch_rs2_val_i,
    input  cdb_t    [NUM_CDB-1:0]     cdb_i,
    input  logic                      flush_i,
    output logic                      busy_o,
    output alu_op_t                   oper_o,
    output word32_t                   rs1_val_o,
    output word32_t                   rs2_val_o,
    output logic                      ready_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BCAST = 2'd2;

    logic [1:0] r_state;
    alu_op_t    r_op;
    word32_t    r_rs1_val;
    word32_t    r_rs2_val;
    rs_tag_t    r_rs1_tag;
    rs_tag_t    r_rs2_tag;

    logic    w_accept;
    logic    w_issue;
    rs_tag_t w_rs1_look;
    rs_tag_t w_rs2_look;
    logic    w_rs1_hit;
    logic    w_rs2_hit;
    word32_t w_rs1_cdb;
    word32_t w_rs2_cdb;
    rs_tag_t w_unused_tag;

    // The station never decodes its own identity; TAG only names the broadcasts it causes.
    assign w_unused_tag = TAG;

    assign busy_o    = (r_state == S_WAIT);
    assign w_issue   = (r_state == S_WAIT) && (r_rs1_tag == NO_VAL) && (r_rs2_tag == NO_VAL);
    assign ready_o   = w_issue;
    assign oper_o    = r_op;
    assign rs1_val_o = r_rs1_val;
    assign rs2_val_o = r_rs2_val;

    assign w_accept   = dispatch_valid_i && !busy_o && !flush_i;
    assign w_rs1_look = w_accept ? dispatch_rs1_tag_i : r_rs1_tag;
    assign w_rs2_look = w_accept ? dispatch_rs2_tag_i : r_rs2_tag;

    // Scanning from the top down lets the lowest matching CDB term win.
    always_comb begin
        w_rs1_hit = 1'b0;
        w_rs1_cdb = '0;
        w_rs2_hit = 1'b0;
        w_rs2_cdb = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if ((w_rs1_look != NO_VAL) && (cdb_i[k].tag == w_rs1_look)) begin
                w_rs1_hit = 1'b1;
                w_rs1_cdb = cdb_i[k].val;
            end
            if ((w_rs2_look != NO_VAL) && (cdb_i[k].tag == w_rs2_look)) begin
                w_rs2_hit = 1'b1;
                w_rs2_cdb = cdb_i[k].val;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_op      <= ADDI;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_rs1_tag <= NO_VAL;
            r_rs2_tag <= NO_VAL;
        end else if (flush_i) begin
            r_state   <= S_IDLE;
            r_rs1_tag <= NO_VAL;
            r_rs2_tag <= NO_VAL;
        end else if (w_accept) begin
            r_state   <= S_WAIT;
            r_op      <= dispatch_op_i;
            r_rs1_val <= w_rs1_hit ? w_rs1_cdb : dispatch_rs1_val_i;
            r_rs2_val <= w_rs2_hit ? w_rs2_cdb : dispatch_rs2_val_i;
            r_rs1_tag <= w_rs1_hit ? NO_VAL : dispatch_rs1_tag_i;
            r_rs2_tag <= w_rs2_hit ? NO_VAL : dispatch_rs2_tag_i;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_issue) begin
                        r_state <= S_BCAST;
                    end else begin
                        if (w_rs1_hit) begin
                            r_rs1_val <= w_rs1_cdb;
                            r_rs1_tag <= NO_VAL;
                        end
                        if (w_rs2_hit) begin
                            r_rs2_val <= w_rs2_cdb;
                            r_rs2_tag <= NO_VAL;
                        end
                    end
                end
                S_BCAST: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs: dispatch, forwarding, CDB snoop,
// back-to-back issue, flush and asynchronous reset.
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int NUM_CDB = 2;

    logic                     clock;
    logic                     reset;
    logic                     dispatchValid;
    alu_op_t                  dispatchOp;
    rs_tag_t                  dispatchRs1Tag;
    word32_t                  dispatchRs1Val;
    rs_tag_t                  dispatchRs2Tag;
    word32_t                  dispatchRs2Val;
    cdb_t    [NUM_CDB-1:0]    cdb;
    logic                     flush;
    logic                     busy;
    alu_op_t                  oper;
    word32_t                  rs1Val;
    word32_t                  rs2Val;
    logic                     ready;

    int nChecks = 0;
    int nFails  = 0;

    alu_rs #(.TAG(ALU_1), .NUM_CDB(NUM_CDB)) dut (
        .clk_i              (clock),
        .reset_i            (reset),
        .dispatch_valid_i   (dispatchValid),
        .dispatch_op_i      (dispatchOp),
        .dispatch_rs1_tag_i (dispatchRs1Tag),
        .dispatch_rs1_val_i (dispatchRs1Val),
        .dispatch_rs2_tag_i (dispatchRs2Tag),
        .dispatch_rs2_val_i (dispatchRs2Val),
        .cdb_i              (cdb),
        .flush_i            (flush),
        .busy_o             (busy),
        .oper_o             (oper),
        .rs1_val_o          (rs1Val),
        .rs2_val_o          (rs2Val),
        .ready_o            (ready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic applyStimulus(input logic valid, input alu_op_t op,
                                 input rs_tag_t t1, input word32_t v1,
                                 input rs_tag_t t2, input word32_t v2);
        dispatchValid  = valid;
        dispatchOp     = op;
        dispatchRs1Tag = t1;
        dispatchRs1Val = v1;
        dispatchRs2Tag = t2;
        dispatchRs2Val = v2;
    endtask

    task automatic idleStimulus();
        applyStimulus(1'b0, ADDI, NO_VAL, 32'h0, NO_VAL, 32'h0);
    endtask

    task automatic setCdb(input int k, input rs_tag_t tag, input word32_t val);
        cdb[k].tag = tag;
        cdb[k].val = val;
    endtask

    task automatic clearCdb();
        for (int k = 0; k < NUM_CDB; k++) setCdb(k, NO_VAL, 32'h0);
    endtask

    // Moves to the next cycle; outputs are then sampled 1 ns after the edge.
    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkIssue(input string tag, input alu_op_t op,
                              input word32_t v1, input word32_t v2);
        checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
        checkOutput({tag, "_oper"}, 32'(oper), 32'(op));
        checkOutput({tag, "_rs1"}, rs1Val, v1);
        checkOutput({tag, "_rs2"}, rs2Val, v2);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        idleStimulus();
        clearCdb();
        nextCycle();
        nextCycle();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_oper", 32'(oper), 32'(ADDI));
        checkOutput("rst_rs1", rs1Val, 32'h0);
        checkOutput("rst_rs2", rs2Val, 32'h0);
        reset = 1'b0;

        // Both operands present: issue in cycle 1, free in cycle 2.
        applyStimulus(1'b1, ADDR, NO_VAL, 32'd3, NO_VAL, 32'd4);
        nextCycle();
        idleStimulus();
        checkIssue("t2_c1", ADDR, 32'd3, 32'd4);
        checkOutput("t2_c1_busy", 32'(busy), 32'd1);
        nextCycle();
        checkOutput("t2_c2_ready", 32'(ready), 32'd0);
        checkOutput("t2_c2_busy", 32'(busy), 32'd0);
        nextCycle();

        // rs1 waits on ALU_2 via cdb[1] in cycle 3; a dispatch while busy is ignored.
        applyStimulus(1'b1, SUBR, ALU_2, 32'h0, NO_VAL, 32'd1);
        nextCycle();
        idleStimulus();
        checkOutput("t3_c1_ready", 32'(ready), 32'd0);
        checkOutput("t3_c1_busy", 32'(busy), 32'd1);
        nextCycle();
        applyStimulus(1'b1, ADDR, NO_VAL, 32'h99, NO_VAL, 32'h98);
        checkOutput("t3_c2_ready", 32'(ready), 32'd0);
        nextCycle();
        idleStimulus();
        setCdb(1, ALU_2, 32'h10);
        checkOutput("t3_c3_ready", 32'(ready), 32'd0);
        checkOutput("t3_c3_busy", 32'(busy), 32'd1);
        nextCycle();
        clearCdb();
        checkIssue("t3_c4", SUBR, 32'h10, 32'd1);
        nextCycle();
        checkOutput("t3_c5_ready", 32'(ready), 32'd0);
        nextCycle();

        // Forwarding at dispatch from cdb[0].
        applyStimulus(1'b1, ANDR, ALU_2, 32'h0, NO_VAL, 32'hF0);
        setCdb(0, ALU_2, 32'hAB);
        nextCycle();
        idleStimulus();
        clearCdb();
        checkIssue("t4", ANDR, 32'hAB, 32'hF0);
        nextCycle();
        nextCycle();

        // Two terms carry the same tag: the lower index wins.
        applyStimulus(1'b1, XORR, NO_VAL, 32'd5, MUL_1, 32'h0);
        setCdb(0, MUL_1, 32'h11);
        setCdb(1, MUL_1, 32'h22);
        nextCycle();
        idleStimulus();
        clearCdb();
        checkIssue("lowk", XORR, 32'd5, 32'h11);
        nextCycle();
        nextCycle();

        // Back-to-back: second op dispatched in BCAST forwards this ALU's result.
        applyStimulus(1'b1, ADDI, NO_VAL, 32'd1, NO_VAL, 32'd1);
        nextCycle();
        idleStimulus();
        checkIssue("t5_c1", ADDI, 32'd1, 32'd1);
        nextCycle();
        checkOutput("t5_c2_busy", 32'(busy), 32'd0);
        checkOutput("t5_c2_ready", 32'(ready), 32'd0);
        applyStimulus(1'b1, ADDR, ALU_1, 32'h0, NO_VAL, 32'd3);
        setCdb(0, ALU_1, 32'd2);
        nextCycle();
        idleStimulus();
        clearCdb();
        checkIssue("t5_c3", ADDR, 32'd2, 32'd3);
        nextCycle();
        checkOutput("t5_c4_ready", 32'(ready), 32'd0);
        nextCycle();

        // Flush in WAIT with a pending tag and a simultaneous dispatch.
        applyStimulus(1'b1, ORR, ALU_2, 32'h0, NO_VAL, 32'd6);
        nextCycle();
        checkOutput("t6_c1_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, ADDR, NO_VAL, 32'd8, NO_VAL, 32'd9);
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        idleStimulus();
        checkOutput("t6_c2_busy", 32'(busy), 32'd0);
        checkOutput("t6_c2_ready", 32'(ready), 32'd0);
        setCdb(0, ALU_2, 32'h55);
        nextCycle();
        clearCdb();
        checkOutput("t6_c3_ready", 32'(ready), 32'd0);
        checkOutput("t6_c3_busy", 32'(busy), 32'd0);
        nextCycle();
        checkOutput("t6_c4_ready", 32'(ready), 32'd0);

        // Flush during issue still shows ready; flush in BCAST blocks a dispatch.
        applyStimulus(1'b1, SLLR, NO_VAL, 32'd4, NO_VAL, 32'd2);
        nextCycle();
        idleStimulus();
        flush = 1'b1;
        checkOutput("fl_issue_ready", 32'(ready), 32'd1);
        nextCycle();
        flush = 1'b0;
        checkOutput("fl_issue_after", 32'(ready), 32'd0);
        applyStimulus(1'b1, ADDI, NO_VAL, 32'd2, NO_VAL, 32'd2);
        nextCycle();
        idleStimulus();
        checkOutput("fl_ok_ready", 32'(ready), 32'd1);
        nextCycle();
        applyStimulus(1'b1, SRLR, NO_VAL, 32'd7, NO_VAL, 32'd1);
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        idleStimulus();
        checkOutput("fl_bcast_busy", 32'(busy), 32'd0);
        checkOutput("fl_bcast_ready", 32'(ready), 32'd0);
        nextCycle();

        // Asynchronous reset in the middle of WAIT, away from any clock edge.
        applyStimulus(1'b1, ORR, ALU_2, 32'h0, NO_VAL, 32'd6);
        nextCycle();
        idleStimulus();
        checkOutput("t1_wait_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t1_async_busy", 32'(busy), 32'd0);
        checkOutput("t1_async_ready", 32'(ready), 32'd0);
        checkOutput("t1_async_oper", 32'(oper), 32'(ADDI));
        checkOutput("t1_async_rs2", rs2Val, 32'h0);
        #1;
        reset = 1'b0;
        nextCycle();
        applyStimulus(1'b1, ADDI, NO_VAL, 32'd5, NO_VAL, 32'd7);
        nextCycle();
        idleStimulus();
        checkIssue("t1_after", ADDI, 32'd5, 32'd7);
        checkOutput("t1_after_busy", 32'(busy), 32'd1);
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
